reg_scoreboard: RTL and testbench

- Dual-issue register scoreboard that sequences access to the 4-read/2-write register file.
- Tracks one busy bit per architectural register, set when an instruction with a destination issues and cleared on writeback.
- Decides each cycle which of the two decode slots may issue, based on RAW/WAW hazards against in-flight producers and within the pair.
- Sits between decode and register read; also keeps a hazard-stall performance counter.

---
 rtl/reg_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_scoreboard.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: per-register busy tracking, RAW/WAW issue gating
// with same-cycle writeback bypass, and a saturating hazard-stall counter.
module reg_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         id_valid,
    input  logic [3:0]         id_src_ena,
    input  logic [4*AW-1:0]    id_src,
    input  logic [1:0]         id_dst_ena,
    input  logic [2*AW-1:0]    id_dst,
    input  logic               back_stall,
    input  logic               flush,
    input  logic [1:0]         wb_ena,
    input  logic [2*AW-1:0]    wb_addr,
    output logic [1:0]         issue_ok,
    output logic [NREG-1:0]    busy_vec,
    output logic [CNT_W-1:0]   stall_cycles
);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [NREG-1:0]  wb_clr;
    logic [NREG-1:0]  eff;
    logic [NREG-1:0]  set_v;
    logic [1:0]       slot_haz;
    logic             pair_haz;
    logic [1:0]       issue_c;
    logic             stall_inc;

    function automatic logic reg_haz(logic ena, logic [AW-1:0] a, logic [NREG-1:0] e);
        return ena && (a != '0) && e[a];
    endfunction

    // Hazard detection, issue decision and next-state computation
    always_comb begin
        wb_clr    = '0;
        set_v     = '0;
        slot_haz  = '0;
        pair_haz  = 1'b0;
        issue_c   = '0;
        stall_inc = 1'b0;
        busy_d    = busy_q;
        stall_d   = stall_q;

        for (int unsigned r = 1; r < NREG; r++) begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (wb_ena[k] && (wb_addr[k*AW +: AW] == AW'(r))) wb_clr[r] = 1'b1;
            end
        end
        eff = busy_q & ~wb_clr;

        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned j = 0; j < 2; j++) begin
                if (reg_haz(id_src_ena[i*2+j], id_src[(i*2+j)*AW +: AW], eff)) slot_haz[i] = 1'b1;
            end
            if (reg_haz(id_dst_ena[i], id_dst[i*AW +: AW], eff)) slot_haz[i] = 1'b1;
        end

        // Slot 1 must not read or overwrite what the older slot 0 produces
        if (id_dst_ena[0] && (id_dst[AW-1:0] != '0)) begin
            for (int unsigned j = 0; j < 2; j++) begin
                if (id_src_ena[2+j] && (id_src[(2+j)*AW +: AW] == id_dst[AW-1:0])) pair_haz = 1'b1;
            end
            if (id_dst_ena[1] && (id_dst[2*AW-1:AW] == id_dst[AW-1:0])) pair_haz = 1'b1;
        end

        issue_c[0] = id_valid[0] & ~back_stall & ~flush & ~rst & ~slot_haz[0];
        issue_c[1] = issue_c[0] & id_valid[1] & ~slot_haz[1] & ~pair_haz;

        for (int unsigned i = 0; i < 2; i++) begin
            if (issue_c[i] && id_dst_ena[i] && (id_dst[i*AW +: AW] != '0)) set_v[id_dst[i*AW +: AW]] = 1'b1;
        end

        if (flush) busy_d = '0;
        else       busy_d = (busy_q & ~wb_clr) | set_v;
        busy_d[0] = 1'b0;

        stall_inc = id_valid[0] & ~back_stall & ~flush & ~issue_c[0];
        if (stall_inc && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign issue_ok     = issue_c;
    assign busy_vec     = busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: table-driven vectors with a queue of
// expected next-cycle state, plus a counter-saturation sequence on a 4-bit build.
module tb_reg_scoreboard;

    localparam int unsigned AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  id_valid;
    logic [3:0]  id_src_ena;
    logic [19:0] id_src;
    logic [1:0]  id_dst_ena;
    logic [9:0]  id_dst;
    logic        back_stall;
    logic        flush;
    logic [1:0]  wb_ena;
    logic [9:0]  wb_addr;
    logic [1:0]  issue_ok, issue_ok4;
    logic [31:0] busy_vec, busy_vec4;
    logic [31:0] stall_cycles;
    logic [3:0]  stall_cycles4;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREG(32), .AW(AW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_ena(id_src_ena),
        .id_src(id_src), .id_dst_ena(id_dst_ena), .id_dst(id_dst),
        .back_stall(back_stall), .flush(flush), .wb_ena(wb_ena), .wb_addr(wb_addr),
        .issue_ok(issue_ok), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    reg_scoreboard #(.NREG(32), .AW(AW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_ena(id_src_ena),
        .id_src(id_src), .id_dst_ena(id_dst_ena), .id_dst(id_dst),
        .back_stall(back_stall), .flush(flush), .wb_ena(wb_ena), .wb_addr(wb_addr),
        .issue_ok(issue_ok4), .busy_vec(busy_vec4), .stall_cycles(stall_cycles4)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [3:0]  src_ena;
        logic [19:0] src;
        logic [1:0]  dst_ena;
        logic [9:0]  dst;
        logic        bs;
        logic        fl;
        logic [1:0]  wbe;
        logic [9:0]  wba;
        logic [1:0]  e_issue;
        logic [31:0] e_busy;
        logic [31:0] e_stall;
    } vec_t;

    typedef struct {
        logic [31:0] busy;
        logic [31:0] stall;
        logic [3:0]  stall4;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(
        input logic r, input logic [1:0] v, input logic [3:0] se,
        input int s00, input int s01, input int s10, input int s11,
        input logic [1:0] de, input int d0, input int d1,
        input logic bs, input logic fl, input logic [1:0] wbe, input int w0, input int w1,
        input logic [1:0] ei, input logic [31:0] eb, input logic [31:0] es);
        vec_t t;
        t.rst = r; t.valid = v; t.src_ena = se;
        t.src = {5'(s11), 5'(s10), 5'(s01), 5'(s00)};
        t.dst_ena = de; t.dst = {5'(d1), 5'(d0)};
        t.bs = bs; t.fl = fl; t.wbe = wbe; t.wba = {5'(w1), 5'(w0)};
        t.e_issue = ei; t.e_busy = eb; t.e_stall = es;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle: issue_ok checked mid-cycle, next-state checked after the edge
    task automatic apply(input vec_t v, input int idx);
        exp_t e, got;
        rst = v.rst; id_valid = v.valid; id_src_ena = v.src_ena; id_src = v.src;
        id_dst_ena = v.dst_ena; id_dst = v.dst; back_stall = v.bs; flush = v.fl;
        wb_ena = v.wbe; wb_addr = v.wba;
        #1;
        chk("issue_ok", idx, 32'(issue_ok), 32'(v.e_issue));
        e.busy = v.e_busy; e.stall = v.e_stall;
        e.stall4 = (v.e_stall > 32'd15) ? 4'hF : 4'(v.e_stall);
        e.idx = idx;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("busy_vec", got.idx, busy_vec, got.busy);
        chk("stall_cycles", got.idx, stall_cycles, got.stall);
        chk("stall_cycles4", got.idx, 32'(stall_cycles4), 32'(got.stall4));
    endtask

    vec_t vecs[$];

    initial begin
        // rst, valid, src_ena, s00,s01,s10,s11, dst_ena, d0,d1, bs, fl, wbe, w0,w1, exp_issue, exp_busy, exp_stall
        vecs.push_back(mk(1, 2'b11, 4'hF, 5, 6, 7, 8, 2'b11, 5, 9, 0, 0, 2'b11, 3, 4, 2'b00, 32'h0, 0));
        vecs.push_back(mk(1, 2'b01, 4'h5, 1, 2, 3, 4, 2'b01, 9, 0, 1, 1, 2'b01, 5, 0, 2'b00, 32'h0, 0));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 2'b01, 32'h20, 0));
        vecs.push_back(mk(0, 2'b01, 4'h1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 32'h20, 1));
        vecs.push_back(mk(0, 2'b01, 4'h1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 5, 0, 2'b01, 32'h0, 1));
        vecs.push_back(mk(0, 2'b11, 4'h4, 0, 0, 3, 0, 2'b01, 3, 0, 0, 0, 2'b00, 0, 0, 2'b01, 32'h8, 1));
        vecs.push_back(mk(0, 2'b00, 4'h0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 3, 2'b00, 32'h0, 1));
        vecs.push_back(mk(0, 2'b11, 4'h0, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 2'b00, 0, 0, 2'b01, 32'h8, 1));
        vecs.push_back(mk(0, 2'b00, 4'h0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 3, 0, 2'b00, 32'h0, 1));
        vecs.push_back(mk(0, 2'b11, 4'h4, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 32'h0, 1));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 7, 0, 0, 0, 2'b00, 0, 0, 2'b01, 32'h80, 1));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 7, 0, 0, 0, 2'b01, 7, 0, 2'b01, 32'h80, 1));
        vecs.push_back(mk(0, 2'b00, 4'h0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 7, 7, 2'b00, 32'h0, 1));
        vecs.push_back(mk(0, 2'b11, 4'h0, 0, 0, 0, 0, 2'b11, 1, 2, 0, 0, 2'b00, 0, 0, 2'b11, 32'h6, 1));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 2'b00, 0, 0, 2'b01, 32'h206, 1));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 10, 0, 0, 1, 2'b11, 1, 2, 2'b00, 32'h0, 1));
        vecs.push_back(mk(0, 2'b10, 4'h0, 0, 0, 0, 0, 2'b10, 0, 4, 0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 1));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 4, 0, 0, 0, 2'b00, 0, 0, 2'b01, 32'h10, 1));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 4, 0, 0, 0, 2'b00, 0, 0, 2'b00, 32'h10, 2));
        vecs.push_back(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 4, 0, 1, 0, 2'b00, 0, 0, 2'b00, 32'h10, 2));
        vecs.push_back(mk(0, 2'b11, 4'h8, 0, 0, 0, 4, 2'b01, 6, 0, 0, 0, 2'b00, 0, 0, 2'b01, 32'h50, 2));

        foreach (vecs[i]) apply(vecs[i], i);

        // Persistent hazard drives the 4-bit counter into saturation
        apply(mk(1, 2'b00, 4'h0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 32'h0, 0), 100);
        apply(mk(0, 2'b01, 4'h0, 0, 0, 0, 0, 2'b01, 4, 0, 0, 0, 2'b00, 0, 0, 2'b01, 32'h10, 0), 101);
        for (int k = 0; k < 18; k++)
            apply(mk(0, 2'b01, 4'h1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 32'h10, 32'(k + 1)), 102 + k);
        for (int k = 0; k < 3; k++)
            apply(mk(0, 2'b01, 4'h1, 4, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 0, 0, 2'b00, 32'h10, 18), 120 + k);
        apply(mk(0, 2'b01, 4'h1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 4, 2'b01, 32'h0, 18), 123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
